// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy count and the default bubble payload.
package pipe_pkg;
  typedef logic [1:0] occ_t;
  localparam int unsigned PIPE_DATA_W = 96;
  localparam logic [PIPE_DATA_W-1:0] PIPE_NOP_DATA = '0;
endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry in-order word store for pipe_latch; head visible the cycle after a push.
// o_rdy is registered (occ<2 after the edge), so nothing combinational reaches it from i_pop.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(PIPE_NOP_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output occ_t              o_occ,
  output logic              o_rdy
);
  logic [DATA_W-1:0] r_ent0, r_ent1;
  occ_t              r_occ;
  logic              r_rdy;
  logic [DATA_W-1:0] w_ent0_nxt, w_ent1_nxt;
  occ_t              w_occ_nxt;

  always_comb begin
    w_ent0_nxt = r_ent0;
    w_ent1_nxt = r_ent1;
    w_occ_nxt  = r_occ;
    if (i_clr) begin
      w_ent0_nxt = NOP_DATA;
      w_ent1_nxt = NOP_DATA;
      w_occ_nxt  = 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            w_ent0_nxt = i_dat;
            w_occ_nxt  = 2'd1;
          end else if (r_occ == 2'd1) begin
            w_ent1_nxt = i_dat;
            w_occ_nxt  = 2'd2;
          end
        end
        2'b01: begin
          if (r_occ != 2'd0) begin
            w_ent0_nxt = (r_occ == 2'd2) ? r_ent1 : NOP_DATA;
            w_ent1_nxt = NOP_DATA;
            w_occ_nxt  = r_occ - 2'd1;
          end
        end
        2'b11: begin
          // Pop and push together: the queue shifts and the new word lands behind whatever remains.
          if (r_occ == 2'd2) begin
            w_ent0_nxt = r_ent1;
            w_ent1_nxt = i_dat;
          end else begin
            w_ent0_nxt = i_dat;
            w_occ_nxt  = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ent0 <= NOP_DATA;
      r_ent1 <= NOP_DATA;
      r_occ  <= 2'd0;
      r_rdy  <= 1'b1;
    end else begin
      r_ent0 <= w_ent0_nxt;
      r_ent1 <= w_ent1_nxt;
      r_occ  <= w_occ_nxt;
      r_rdy  <= (w_occ_nxt != 2'd2);
    end
  end

  assign o_head = r_ent0;
  assign o_occ  = r_occ;
  assign o_rdy  = r_rdy;
endmodule

// File: rtl/pipe_latch.sv
// Valid/ready pipeline stage with hold (bubble) and flush; 1-cycle latency when empty.
// Build option PIPE_LATCH_SKID_EN: 2-entry skid with registered in_ready; else 1 entry, in_ready follows out_ready.
module pipe_latch
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(PIPE_NOP_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_nop,
  output logic [1:0]        occ
);
  logic              w_in_fire;
  logic              w_out_fire;
  logic [DATA_W-1:0] w_head;
  occ_t              w_occ;

  // Nothing is presented during flush, so a downstream handshake never consumes a dropped word.
  assign out_valid  = rst && !flush && !hold && (w_occ != 2'd0);
  assign out_data   = out_valid ? w_head : NOP_DATA;
  assign out_nop    = !out_valid;
  assign occ        = w_occ;
  assign w_in_fire  = in_valid && in_ready && !flush;
  assign w_out_fire = out_valid && out_ready;

`ifdef PIPE_LATCH_SKID_EN
  logic w_buf_rdy;

  pipe_skid_buf #(
    .DATA_W   (DATA_W),
    .NOP_DATA (NOP_DATA)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (flush),
    .i_push (w_in_fire),
    .i_dat  (in_data),
    .i_pop  (w_out_fire),
    .o_head (w_head),
    .o_occ  (w_occ),
    .o_rdy  (w_buf_rdy)
  );

  assign in_ready = rst && !hold && w_buf_rdy;
`else
  logic              r_vld;
  logic [DATA_W-1:0] r_dat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= 1'b0;
      r_dat <= NOP_DATA;
    end else if (flush) begin
      r_vld <= 1'b0;
      r_dat <= NOP_DATA;
    end else if (w_in_fire) begin
      r_vld <= 1'b1;
      r_dat <= in_data;
    end else if (w_out_fire) begin
      r_vld <= 1'b0;
      r_dat <= NOP_DATA;
    end
  end

  assign in_ready = rst && !hold && (!r_vld || out_ready);
  assign w_head   = r_dat;
  assign w_occ    = {1'b0, r_vld};
`endif
endmodule

// File: tb/tb_pipe_latch.sv
// Randomized scoreboard bench for pipe_latch; the model is a plain queue of accepted words.
module tb_pipe_latch;
  import pipe_pkg::*;

  localparam int DW = 96;
  localparam logic [DW-1:0] NOP = '0;
`ifdef PIPE_LATCH_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, hold, flush, out_valid, out_ready, out_nop;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occ;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_out   = 0;
  bit            chk_on  = 1'b0;
  logic [DW-1:0] last_out = '0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_latch #(.DATA_W(DW), .NOP_DATA(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .hold      (hold),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nop   (out_nop),
    .occ       (occ)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; status outputs are predicted from the model queue before the edge.
  task automatic cyc(input bit r, input bit iv, input logic [DW-1:0] d,
                     input bit h, input bit f, input bit ordy);
    bit e_rdy, e_vld;
    int sz;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; hold = h; flush = f; out_ready = ordy;
    #1;
    sz    = exp_q.size();
    e_rdy = r && !h && ((CAP == 2) ? (sz < 2) : (sz == 0 || ordy));
    e_vld = r && !f && !h && (sz > 0);
    if (chk_on) begin
      chk("in_ready",  DW'(in_ready),  DW'(e_rdy));
      chk("out_valid", DW'(out_valid), DW'(e_vld));
      chk("out_nop",   DW'(out_nop),   DW'(!e_vld));
      chk("occ",       DW'(occ),       DW'(sz));
      chk("out_data",  out_data,       e_vld ? exp_q[0] : NOP);
    end
    @(posedge clk);
    if (!r || f) exp_q.delete();
    else if (iv && e_rdy) exp_q.push_back(d);
    if (!r) chk_on = 1'b1;
  endtask

  // Monitor: every output handshake must deliver the oldest outstanding accepted word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_on && out_valid && out_ready) begin
        n_out++;
        last_out = out_data;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mon_unexpected: got %h expected no word", out_data);
        end else begin
          chk("mon_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n0;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; hold = 1'b0; flush = 1'b0; out_ready = 1'b0;

    cyc(0, 0, '0, 0, 0, 0);
    cyc(0, 1, 96'h5, 0, 0, 1);

    // Single word into an empty stage
    cyc(1, 1, 96'h0A, 0, 0, 1);
    #1;
    chk("r031_valid", DW'(out_valid), DW'(1));
    chk("r031_data",  out_data, 96'h0A);
    chk("r031_occ",   DW'(occ), DW'(1));
    cyc(1, 0, '0, 0, 0, 1);

    // Back-to-back stream, one word per cycle
    n0 = n_out;
    for (int i = 1; i <= 16; i++) cyc(1, 1, DW'(i), 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, 0, 1);
    chk("r032_count", DW'(n_out - n0), DW'(16));
    chk("r032_last",  last_out, 96'h10);

    // Hold freezes the head and shows a bubble
    cyc(1, 1, 96'h22, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 96'h99, 1, 0, 1);
      #1;
      chk("r033_nop_data", out_data, NOP);
      chk("r033_occ",      DW'(occ), DW'(1));
    end
    cyc(1, 0, '0, 0, 0, 1);
    chk("r033_release", last_out, 96'h22);

    // Fill with a stalled sink, then drain in order
    cyc(1, 1, 96'h31, 0, 0, 0);
    cyc(1, 1, 96'h32, 0, 0, 0);
    cyc(1, 1, 96'h33, 0, 0, 0);
    #1;
    chk("r034_occ",   DW'(occ), DW'(CAP));
    chk("r034_ready", DW'(in_ready), DW'(0));
    n0 = n_out;
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, 0, 1);
    chk("r034_count", DW'(n_out - n0), DW'(CAP));
    chk("r034_last",  last_out, (CAP == 2) ? 96'h32 : 96'h31);

    // Flush with a word on offer
    cyc(1, 1, 96'h41, 0, 0, 0);
    cyc(1, 1, 96'h42, 0, 0, 0);
    cyc(1, 1, 96'h44, 0, 1, 0);
    #1;
    chk("r035_occ",   DW'(occ), DW'(0));
    chk("r035_valid", DW'(out_valid), DW'(0));
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, 0, 1);

    // Reset mid-transfer
    cyc(1, 1, 96'h55, 0, 0, 0);
    cyc(0, 1, 96'h66, 0, 0, 1);
    #1;
    chk("r036_occ",   DW'(occ), DW'(0));
    chk("r036_data",  out_data, NOP);
    chk("r036_ready", DW'(in_ready), DW'(0));
    cyc(1, 1, 96'h77, 0, 0, 1);
    cyc(1, 0, '0, 0, 0, 1);
    chk("r036_after", last_out, 96'h77);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 9) < 7),
          {$urandom(), $urandom(), $urandom()},
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 6));
    end

    for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0, 0, 1);
    #1;
    chk("drain_occ", DW'(occ), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
